// File: rtl/bsg_div_restoring_iterative_pkg.sv
// Shared arithmetic-unit definitions: FSM state encodings for the iterative divider and multiplier.
package bsg_div_restoring_iterative_pkg;

    typedef enum logic [2:0] {
        eIdle,
        ePre,
        eCal,
        eFix,
        eDone
    } bsg_div_state_e;

    typedef enum logic [1:0] {
        eMulIdle,
        eMulCalc,
        eMulDone
    } bsg_mul_state_e;

endpackage

// File: rtl/bsg_div_restoring_iterative_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor, keep or restore.
module bsg_div_restoring_step #(
    parameter int width_p = 32
) (
    input  logic [width_p-1:0] rem_i,
    input  logic               dividend_bit_i,
    input  logic [width_p-1:0] divisor_i,
    output logic [width_p-1:0] rem_o,
    output logic               quot_bit_o
);

    logic [width_p:0] shifted;
    logic [width_p:0] diff;

    // rem_i < divisor_i always holds, so the width_p+1-bit difference's MSB is a valid borrow flag
    assign shifted    = {rem_i, dividend_bit_i};
    assign diff       = shifted - {1'b0, divisor_i};
    assign quot_bit_o = ~diff[width_p];
    assign rem_o      = quot_bit_o ? diff[width_p-1:0] : shifted[width_p-1:0];

endmodule

// File: rtl/bsg_div_restoring_iterative.sv
// Iterative restoring divider, signed or unsigned, one quotient bit per cycle with valid/yumi output handshake.
module bsg_div_restoring_iterative
    import bsg_div_restoring_iterative_pkg::*;
#(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               ready_o,
    input  logic [width_p-1:0] dividend_i,
    input  logic [width_p-1:0] divisor_i,
    input  logic               signed_i,
    input  logic               v_i,
    output logic [width_p-1:0] quotient_o,
    output logic [width_p-1:0] remainder_o,
    output logic               v_o,
    input  logic               yumi_i
);

    localparam int cnt_w_lp = $clog2(width_p);

    bsg_div_state_e        state_q, state_d;
    logic [width_p-1:0]    quot_q, quot_d;
    logic [width_p-1:0]    rem_q, rem_d;
    logic [width_p-1:0]    dvsr_q, dvsr_d;
    logic                  signed_q, signed_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;
    logic                  dz_q, dz_d;
    logic [cnt_w_lp-1:0]   cnt_q, cnt_d;

    logic [width_p-1:0]    step_rem;
    logic                  step_bit;
    logic [width_p-1:0]    neg_b_in;
    logic [width_p-1:0]    neg_a;
    logic [width_p-1:0]    neg_b;

    bsg_div_restoring_step #(.width_p(width_p)) step_u (
        .rem_i         (rem_q),
        .dividend_bit_i(quot_q[width_p-1]),
        .divisor_i     (dvsr_q),
        .rem_o         (step_rem),
        .quot_bit_o    (step_bit)
    );

    // Negators are shared: ePre takes |dividend|,|divisor|; eFix signs quotient,remainder
    assign neg_b_in = (state_q == ePre) ? dvsr_q : rem_q;
    assign neg_a    = ~quot_q + width_p'(1);
    assign neg_b    = ~neg_b_in + width_p'(1);

    always_comb begin
        state_d  = state_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dvsr_d   = dvsr_q;
        signed_d = signed_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        dz_d     = dz_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            eIdle: begin
                if (v_i) begin
                    quot_d   = dividend_i;
                    dvsr_d   = divisor_i;
                    signed_d = signed_i;
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = ePre;
                end
            end
            ePre: begin
                q_neg_d = signed_q & (quot_q[width_p-1] ^ dvsr_q[width_p-1]);
                r_neg_d = signed_q & quot_q[width_p-1];
                dz_d    = (dvsr_q == '0);
                if (signed_q && quot_q[width_p-1]) quot_d = neg_a;
                if (signed_q && dvsr_q[width_p-1]) dvsr_d = neg_b;
                state_d = eCal;
            end
            eCal: begin
                rem_d  = step_rem;
                quot_d = {quot_q[width_p-2:0], step_bit};
                cnt_d  = cnt_q + cnt_w_lp'(1);
                if (cnt_q == cnt_w_lp'(width_p - 1)) state_d = eFix;
            end
            eFix: begin
                // Divide-by-zero keeps the all-ones quotient regardless of operand signs
                if (q_neg_q && !dz_q) quot_d = neg_a;
                if (r_neg_q) rem_d = neg_b;
                state_d = eDone;
            end
            eDone: begin
                if (yumi_i) state_d = eIdle;
            end
            default: state_d = eIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= eIdle;
            quot_q   <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            signed_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dvsr_q   <= dvsr_d;
            signed_q <= signed_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            dz_q     <= dz_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ready_o     = (state_q == eIdle);
    assign v_o         = (state_q == eDone);
    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;

endmodule

// File: tb/tb_bsg_div_restoring_iterative.sv
// Scoreboard bench for bsg_div_restoring_iterative: driver queues expected results, monitor retires them.
module tb_bsg_div_restoring_iterative;

    localparam int W   = 32;
    localparam int LAT = W + 3;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         ready_o;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic         signed_i;
    logic         v_i;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;
    logic         v_o;
    logic         yumi_i;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   auto_yumi = 1'b1;
    bit   manual_yumi = 1'b0;

    always #5 clk = ~clk;

    bsg_div_restoring_iterative #(.width_p(W)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .ready_o    (ready_o),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .signed_i   (signed_i),
        .v_i        (v_i),
        .quotient_o (quotient_o),
        .remainder_o(remainder_o),
        .v_o        (v_o),
        .yumi_i     (yumi_i)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, remainder takes dividend's sign
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t   e;
        longint sa;
        longint sb;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else if (!s) begin
            e.q = a / b;
            e.r = a % b;
        end else begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            e.q = W'(sa / sb);
            e.r = W'(sa % sb);
        end
        return e;
    endfunction

    // Monitor: retire one expected result per presented output
    initial begin : monitor
        bit   taken;
        exp_t e;
        taken  = 1'b0;
        yumi_i = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                taken  = 1'b0;
                yumi_i = 1'b0;
            end else begin
                if (v_o && !taken) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got q=%h r=%h, expected no result", quotient_o, remainder_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("quotient", quotient_o, e.q);
                        check("remainder", remainder_o, e.r);
                    end
                    taken = 1'b1;
                end
                if (!v_o) taken = 1'b0;
                yumi_i = auto_yumi ? v_o : manual_yumi;
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input bit push, input exp_t e);
        int i;
        for (i = 0; i < 200 && !ready_o; i++) @(negedge clk);
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready_o=0, expected 1");
        end
        if (push) exp_q.push_back(e);
        dividend_i = a;
        divisor_i  = b;
        signed_i   = s;
        v_i        = 1'b1;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            v_i = 1'b0;
            if (v_o) break;
        end
        if (!v_o) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: got v_o=0, expected 1");
        end
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 50 && !(ready_o && exp_q.size() == 0); i++) @(negedge clk);
        if (!(ready_o && exp_q.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got pending=%0d, expected 0", exp_q.size());
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input exp_t e);
        int lat;
        issue(a, b, s, 1'b1, e);
        wait_result(lat);
        check({name, "_latency"}, W'(lat), W'(LAT));
        wait_drain();
    endtask

    initial begin : driver
        exp_t         e;
        logic [W-1:0] a, b, q0, r0;
        logic         s;
        int           lat;
        bit           seen;

        reset_i    = 1'b1;
        v_i        = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        signed_i   = 1'b0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        check("reset_ready", W'(ready_o), W'(1));
        check("reset_v_o", W'(v_o), W'(0));
        check("reset_quotient", quotient_o, '0);
        check("reset_remainder", remainder_o, '0);

        // Directed cases with hand-computed expectations
        run_op("u100_7",   32'd100,        32'd7,          1'b0, '{q: 32'h0000000E, r: 32'h00000002});
        run_op("s-7_2",    32'hFFFFFFF9,   32'd2,          1'b1, '{q: 32'hFFFFFFFD, r: 32'hFFFFFFFF});
        run_op("uFFF9_2",  32'hFFFFFFF9,   32'd2,          1'b0, '{q: 32'h7FFFFFFC, r: 32'h00000001});
        run_op("u5_0",     32'd5,          32'd0,          1'b0, '{q: 32'hFFFFFFFF, r: 32'h00000005});
        run_op("s-5_0",    32'hFFFFFFFB,   32'd0,          1'b1, '{q: 32'hFFFFFFFF, r: 32'hFFFFFFFB});
        run_op("smin_-1",  32'h80000000,   32'hFFFFFFFF,   1'b1, '{q: 32'h80000000, r: 32'h00000000});
        run_op("s7_-2",    32'd7,          32'hFFFFFFFE,   1'b1, '{q: 32'hFFFFFFFD, r: 32'h00000001});
        run_op("s-8_-3",   32'hFFFFFFF8,   32'hFFFFFFFD,   1'b1, '{q: 32'h00000002, r: 32'hFFFFFFFE});

        // Randomised operands against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = W'($urandom_range(1, 20));
                2: b = -W'($urandom_range(1, 20));
                3: b = '0;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            s = 1'($urandom_range(0, 1));
            run_op("random", a, b, s, model(a, b, s));
        end

        // Backpressure: result held while yumi_i stays low, v_i pulses ignored
        auto_yumi = 1'b0;
        issue(32'h00001234, 32'h00000010, 1'b0, 1'b1, model(32'h00001234, 32'h00000010, 1'b0));
        wait_result(lat);
        q0 = quotient_o;
        r0 = remainder_o;
        for (int i = 0; i < 10; i++) begin
            v_i        = 1'(i % 2);
            dividend_i = $urandom;
            divisor_i  = $urandom;
            @(negedge clk);
            check("hold_v_o", W'(v_o), W'(1));
            check("hold_quotient", quotient_o, q0);
            check("hold_remainder", remainder_o, r0);
        end
        v_i = 1'b0;
        @(posedge clk);
        #1;
        manual_yumi = 1'b1;
        v_i         = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("retire_ready", W'(ready_o), W'(1));
        check("retire_v_o", W'(v_o), W'(0));
        v_i         = 1'b0;
        manual_yumi = 1'b0;
        auto_yumi   = 1'b1;
        @(negedge clk);
        check("retire_no_accept", W'(ready_o), W'(1));

        // Reset mid-calculation abandons the operation
        issue(32'd7, 32'd1, 1'b0, 1'b0, '0);
        @(negedge clk);
        v_i = 1'b0;
        repeat (10) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check("abort_ready", W'(ready_o), W'(1));
        check("abort_quotient", quotient_o, '0);
        check("abort_remainder", remainder_o, '0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (v_o) seen = 1'b1;
        end
        check("abort_no_v_o", W'(seen), W'(0));
        run_op("u9_3", 32'd9, 32'd3, 1'b0, '{q: 32'd3, r: 32'd0});

        repeat (3) @(negedge clk);
        check("scoreboard_empty", W'(exp_q.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
